// File: rtl/mac_array.sv
// Multi-lane signed multiply-accumulate over a frame of beats, with bias and
// saturating accumulation; one result strobe per frame.
module mac_array #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned LANES    = 4,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned LEN_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic [ACC_W-1:0]          bias,
    input  logic                      valid,
    output logic                      ready,
    input  logic [LANES*DATA_W-1:0]   data,
    input  logic [LANES*WEIGHT_W-1:0] weight,
    output logic [ACC_W-1:0]          out,
    output logic                      outValid,
    output logic                      overflow,
    output logic                      busy
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
    localparam int unsigned EXT_W  = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   r_state;
    logic [LEN_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]         r_out;
    logic                     r_out_valid;
    logic                     r_overflow;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_zero_pend;

    logic signed [PROD_W-1:0] r_prod [LANES];
    logic                     r_p_valid;
    logic                     r_p_last;
    logic signed [SUM_W-1:0]  r_sum;
    logic                     r_s_valid;
    logic                     r_s_last;

    logic                     w_accept;
    logic                     w_last_beat;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [EXT_W-1:0]  w_ext;
    logic                     w_ovf;
    logic signed [ACC_W-1:0]  w_sat;

    assign w_accept    = valid && r_ready;
    assign w_last_beat = (r_cnt == LEN_W'(1));

    // Lane sum is sized so it can never overflow.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_sum = w_sum + SUM_W'(r_prod[i]);
        end
    end

    // One guard bit catches overflow in either direction; clamp to the rail.
    assign w_ext = EXT_W'(r_acc) + EXT_W'(r_sum);
    assign w_ovf = w_ext[ACC_W] ^ w_ext[ACC_W-1];
    assign w_sat = !w_ovf         ? w_ext[ACC_W-1:0] :
                   w_ext[ACC_W]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};

    // Stage 1 registers lane products, stage 1b the lane sum, each with flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LANES); i++) begin
                r_prod[i] <= '0;
            end
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_sum     <= '0;
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    r_prod[i] <= $signed(data[i*DATA_W +: DATA_W]) *
                                 $signed(weight[i*WEIGHT_W +: WEIGHT_W]);
                end
            end
            r_p_valid <= w_accept;
            r_p_last  <= w_accept && w_last_beat;
            r_sum     <= w_sum;
            r_s_valid <= r_p_valid;
            r_s_last  <= r_p_last;
        end
    end

    // Frame control, accumulator and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_zero_pend <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;

            // An empty frame reports its bias one cycle after start.
            if (r_zero_pend) begin
                r_out       <= r_acc;
                r_out_valid <= 1'b1;
                r_zero_pend <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_overflow <= 1'b0;
                        r_acc      <= bias;
                        if (len == '0) begin
                            r_zero_pend <= 1'b1;
                        end else begin
                            r_cnt   <= len;
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (w_last_beat) begin
                            r_state <= S_DRAIN;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

            if (r_s_valid) begin
                r_acc <= w_sat;
                if (w_ovf) begin
                    r_overflow <= 1'b1;
                end
                if (r_s_last) begin
                    r_out       <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                end
            end
        end
    end

    assign ready    = r_ready;
    assign out      = r_out;
    assign outValid = r_out_valid;
    assign overflow = r_overflow;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: directed scenarios plus randomized frames
// compared against a beat-by-beat saturating dot-product model.
module tb_mac_array;

    localparam int DATA_W   = 8;
    localparam int WEIGHT_W = 8;
    localparam int LANES    = 4;
    localparam int ACC_W    = 24;
    localparam int LEN_W    = 8;
    localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W - 1));

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic [LEN_W-1:0]          len;
    logic [ACC_W-1:0]          bias;
    logic                      valid;
    logic                      ready;
    logic [LANES*DATA_W-1:0]   data;
    logic [LANES*WEIGHT_W-1:0] weight;
    logic [ACC_W-1:0]          out;
    logic                      outValid;
    logic                      overflow;
    logic                      busy;

    int checks;
    int errors;

    int bd [256][LANES];
    int bw [256][LANES];
    bit vpat [$];

    mac_array #(
        .DATA_W  (DATA_W),
        .WEIGHT_W(WEIGHT_W),
        .LANES   (LANES),
        .ACC_W   (ACC_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .len     (len),
        .bias    (bias),
        .valid   (valid),
        .ready   (ready),
        .data    (data),
        .weight  (weight),
        .out     (out),
        .outValid(outValid),
        .overflow(overflow),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint model(input longint b, input int n, output bit ovf);
        longint acc;
        longint s;
        ovf = 1'b0;
        acc = b;
        for (int k = 0; k < n; k++) begin
            s = acc;
            for (int i = 0; i < LANES; i++) begin
                s += longint'(bd[k][i]) * longint'(bw[k][i]);
            end
            if (s > MAXV) begin
                s = MAXV;
                ovf = 1'b1;
            end else if (s < MINV) begin
                s = MINV;
                ovf = 1'b1;
            end
            acc = s;
        end
        return acc;
    endfunction

    task automatic fill_basic(input int k);
        for (int i = 0; i < LANES; i++) begin
            bd[k][i] = i + 1;
            bw[k][i] = i + 5;
        end
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < LANES; i++) begin
                bd[k][i] = int'($urandom_range(255)) - 128;
                bw[k][i] = int'($urandom_range(255)) - 128;
            end
        end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < LANES; i++) begin
            data[i*DATA_W +: DATA_W]       = DATA_W'(bd[k][i]);
            weight[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(bw[k][i]);
        end
    endtask

    // Runs one frame from start through outValid; returns observations only.
    task automatic do_frame(input int n, input longint b, input int gap_pct,
                            input bit hold_valid, input bit poke_start,
                            output longint got, output bit got_ovf, output int lat,
                            output bit rdy_start, output bit rdy_last,
                            output bit busy_seen, output bit tmo);
        int idx;
        int cyc;
        bit v;
        bit acc;
        tmo       = 1'b0;
        busy_seen = 1'b0;
        rdy_last  = 1'b1;
        start = 1'b1;
        len   = LEN_W'(n);
        bias  = ACC_W'(b);
        tick();
        start     = 1'b0;
        rdy_start = ready;
        busy_seen = busy;
        idx = 0;
        cyc = 0;
        while (idx < n) begin
            if (cyc > 4000) begin
                tmo = 1'b1;
                break;
            end
            if (vpat.size() > 0) v = vpat.pop_front();
            else v = ($urandom_range(99) >= gap_pct);
            drive_beat(idx);
            valid = v;
            if (poke_start && cyc == 1) begin
                start = 1'b1;
                len   = LEN_W'(7);
                bias  = ACC_W'(12345);
            end else begin
                start = 1'b0;
            end
            acc = v && ready;
            tick();
            cyc++;
            if (acc) idx++;
            if (idx == n) rdy_last = ready;
        end
        start = 1'b0;
        valid = hold_valid;
        lat = 0;
        while (outValid !== 1'b1 && !tmo) begin
            if (lat > 20) begin
                tmo = 1'b1;
            end else begin
                tick();
                lat++;
                busy_seen |= busy;
            end
        end
        got     = longint'($signed(out));
        got_ovf = overflow;
        valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        longint got, exp;
        bit ovf, eovf, rs, rl, bs, tmo;
        int lat;
        fill_basic(0);
        exp = model(0, 1, eovf);
        do_frame(1, 0, 0, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL basic_timeout: got timeout expected outValid"); end
        checks++; if (got != 70 || got != exp) begin errors++; $display("FAIL basic_out: got %0d expected %0d", got, exp); end
        checks++; if (ovf !== eovf) begin errors++; $display("FAIL basic_overflow: got %b expected %b", ovf, eovf); end
        checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL basic_ready_after_start: got %b expected 1", rs); end
        checks++; if (rl !== 1'b0) begin errors++; $display("FAIL basic_ready_after_last: got %b expected 0", rl); end
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got %b expected 0", outValid); end
        checks++; if ($signed(out) != 70) begin errors++; $display("FAIL basic_out_hold: got %0d expected 70", $signed(out)); end
    endtask

    task automatic test_signed_bias();
        longint got, exp;
        bit ovf, eovf, rs, rl, bs, tmo;
        int lat;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < LANES; i++) begin
                bd[k][i] = -128;
                bw[k][i] = 127;
            end
        end
        exp = model(100, 3, eovf);
        do_frame(3, 100, 0, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL signed_timeout: got timeout expected outValid"); end
        checks++; if (got != -194972 || got != exp) begin errors++; $display("FAIL signed_out: got %0d expected %0d", got, exp); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL signed_overflow: got %b expected 0", ovf); end
    endtask

    task automatic test_saturation();
        longint got, exp;
        bit ovf, eovf, rs, rl, bs, tmo;
        int lat;
        for (int k = 0; k < 255; k++) begin
            for (int i = 0; i < LANES; i++) begin
                bd[k][i] = -128;
                bw[k][i] = -128;
            end
        end
        exp = model(0, 255, eovf);
        do_frame(255, 0, 0, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL sat_timeout: got timeout expected outValid"); end
        checks++; if (got != 8388607 || got != exp) begin errors++; $display("FAIL sat_out: got %0d expected %0d", got, exp); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b expected 1", ovf); end
        tick();
        tick();
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow_hold: got %b expected 1", overflow); end
        fill_basic(0);
        do_frame(1, 0, 0, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
        checks++; if (got != 70) begin errors++; $display("FAIL sat_next_out: got %0d expected 70", got); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_next_overflow: got %b expected 0", ovf); end
    endtask

    task automatic test_handshake();
        longint got, exp;
        bit ovf, eovf, rs, rl, bs, tmo;
        int lat;
        bit stray;
        fill_random(4);
        exp = model(-777, 4, eovf);
        vpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_frame(4, -777, 0, 1, 1, got, ovf, lat, rs, rl, bs, tmo);
        vpat.delete();
        checks++; if (tmo) begin errors++; $display("FAIL hs_timeout: got timeout expected outValid"); end
        checks++; if (got != exp) begin errors++; $display("FAIL hs_out: got %0d expected %0d", got, exp); end
        checks++; if (ovf !== eovf) begin errors++; $display("FAIL hs_overflow: got %b expected %b", ovf, eovf); end
        checks++; if (rl !== 1'b0) begin errors++; $display("FAIL hs_ready_after_last: got %b expected 0", rl); end
        checks++; if (lat != 2) begin errors++; $display("FAIL hs_latency: got %0d expected 2", lat); end
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (outValid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("FAIL hs_poked_start: got extra activity expected idle"); end
    endtask

    task automatic test_len_zero();
        longint got;
        bit ovf, rs, rl, bs, tmo;
        int lat;
        do_frame(0, -5, 0, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL len0_timeout: got timeout expected outValid"); end
        checks++; if (got != -5) begin errors++; $display("FAIL len0_out: got %0d expected -5", got); end
        checks++; if (lat != 1) begin errors++; $display("FAIL len0_latency: got %0d expected 1", lat); end
        checks++; if (bs !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b expected 0", bs); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL len0_overflow: got %b expected 0", ovf); end
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL len0_strobe_width: got %b expected 0", outValid); end
    endtask

    task automatic test_reset_mid_frame();
        longint got;
        bit ovf, rs, rl, bs, tmo;
        int lat;
        bit seen;
        fill_random(4);
        start = 1'b1;
        len   = LEN_W'(4);
        bias  = ACC_W'(0);
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_beat(k);
            valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (out !== '0) begin errors++; $display("FAIL rstmid_out: got %0d expected 0", out); end
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL rstmid_busy_ready: got %b%b expected 00", busy, ready); end
        checks++; if (outValid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %b%b expected 00", outValid, overflow); end
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (outValid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_outValid: got pulse expected none"); end
        fill_basic(0);
        do_frame(1, 0, 0, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
        checks++; if (got != 70) begin errors++; $display("FAIL rstmid_next_out: got %0d expected 70", got); end
    endtask

    task automatic test_back_to_back();
        longint got, exp;
        bit ovf, eovf, rs, rl, bs, tmo;
        int lat;
        for (int f = 0; f < 3; f++) begin
            fill_random(2);
            exp = model(longint'(f * 1000 - 1500), 2, eovf);
            do_frame(2, longint'(f * 1000 - 1500), 0, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
            checks++; if (rs !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_start[%0d]: got %b expected 1", f, rs); end
            checks++; if (got != exp) begin errors++; $display("FAIL b2b_out[%0d]: got %0d expected %0d", f, got, exp); end
        end
    endtask

    task automatic test_random();
        longint got, exp, b;
        bit ovf, eovf, rs, rl, bs, tmo;
        int lat;
        int n;
        for (int f = 0; f < 24; f++) begin
            n = int'($urandom_range(16, 1));
            fill_random(n);
            case ($urandom_range(3))
                0: b = MAXV - longint'($urandom_range(60000));
                1: b = MINV + longint'($urandom_range(60000));
                default: b = longint'($urandom_range(200000)) - 100000;
            endcase
            exp = model(b, n, eovf);
            do_frame(n, b, 30, 0, 0, got, ovf, lat, rs, rl, bs, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL rand_timeout[%0d]: got timeout expected outValid", f); end
            checks++; if (got != exp) begin errors++; $display("FAIL rand_out[%0d]: got %0d expected %0d", f, got, exp); end
            checks++; if (ovf !== eovf) begin errors++; $display("FAIL rand_overflow[%0d]: got %b expected %b", f, ovf, eovf); end
            checks++; if (lat != 2) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 2", f, lat); end
        end
    endtask

    initial begin
        clk    = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        len    = '0;
        bias   = '0;
        valid  = 1'b0;
        data   = '0;
        weight = '0;
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_signed_bias();
        test_saturation();
        test_handshake();
        test_len_zero();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
